hb_interp2: RTL and testbench

Half-band interpolate-by-2 FIR. It is the transmit-side counterpart of the half-band decimating FIR in the same filter family.
- Accepts one signed sample per input handshake.
- Emits two output samples per input: even phase, then odd phase.
- Uses a fixed 7-tap half-band kernel [-1,0,9,16,9,0,-1]/16 in polyphase form.
- Sits between a low-rate sample source and a 2x-rate consumer, with valid/ready on both sides.

---
 rtl/hb_interp2.sv | 132 +++++++++++++
 tb/tb_hb_interp2.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hb_interp2.sv
// hb_interp2: half-band interpolate-by-2 FIR, kernel [-1,0,9,16,9,0,-1]/16 in
// polyphase form. Each accepted input yields an even (center-tap) output and
// then an odd (interpolated) output.
// Build option: define HB_INTERP2_SAT_EN to saturate the odd path to DATA_W;
// left undefined, the odd path wraps to its low DATA_W bits.
module hb_interp2 #(
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_phase,
  input  logic                     i_ready
);

  // Headroom: 9*(2*max) + 2*max + rounding fits in DATA_W+5 signed bits.
  localparam int ACC_W = DATA_W + 5;
  localparam logic signed [ACC_W-1:0] K9      = ACC_W'(9);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(8);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W-1)));

  typedef enum logic [1:0] {S_ACCEPT, S_EVEN, S_ODD} state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic signed [DATA_W-1:0]   odd_q, odd_d;
  logic signed [DATA_W-1:0]   o_data_q, o_data_d;
  logic                       o_valid_q, o_valid_d;
  logic                       o_phase_q, o_phase_d;

  logic signed [ACC_W-1:0]    acc, odd_full;
  logic signed [DATA_W-1:0]   odd_red;
  logic                       accept, xfer;

  assign o_ready = (state_q == S_ACCEPT) || ((state_q == S_ODD) && i_ready);
  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid_q && i_ready;

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_phase = o_phase_q;

  // Odd phase uses the pre-shift delay line plus the incoming sample.
  assign acc      = K9 * (ACC_W'(d2_q) + ACC_W'(d1_q))
                  - (ACC_W'(d3_q) + ACC_W'(i_data)) + RND;
  assign odd_full = acc >>> 4;

`ifdef HB_INTERP2_SAT_EN
  // Clamp the odd result into the DATA_W signed range.
  always_comb begin
    if (odd_full > SAT_MAX)      odd_red = SAT_MAX[DATA_W-1:0];
    else if (odd_full < SAT_MIN) odd_red = SAT_MIN[DATA_W-1:0];
    else                         odd_red = odd_full[DATA_W-1:0];
  end
`else
  // Wrap: keep only the low DATA_W bits of the odd result.
  logic unused_odd_hi;
  assign unused_odd_hi = ^{odd_full[ACC_W-1:DATA_W], SAT_MAX, SAT_MIN};
  always_comb odd_red = odd_full[DATA_W-1:0];
`endif

  // Next-state and datapath updates for the accept/even/odd sequence.
  always_comb begin
    state_d   = state_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    odd_d     = odd_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    o_phase_d = o_phase_q;
    case (state_q)
      S_ACCEPT: ;
      S_EVEN: begin
        if (xfer) begin
          o_data_d  = odd_q;
          o_phase_d = 1'b1;
          state_d   = S_ODD;
        end
      end
      S_ODD: begin
        if (xfer && !accept) begin
          o_valid_d = 1'b0;
          o_phase_d = 1'b0;
          state_d   = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase
    // A load only happens in S_ACCEPT or in S_ODD alongside the odd transfer,
    // so it takes priority over the hold/drain decisions above.
    if (accept) begin
      odd_d     = odd_red;
      d3_d      = d2_q;
      d2_d      = d1_q;
      d1_d      = i_data;
      o_data_d  = d2_q;
      o_phase_d = 1'b0;
      o_valid_d = 1'b1;
      state_d   = S_EVEN;
    end
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_ACCEPT;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      odd_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_phase_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      odd_q     <= odd_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_phase_q <= o_phase_d;
    end
  end

endmodule

// File: tb/tb_hb_interp2.sv
// tb_hb_interp2: directed vectors for hb_interp2 (DATA_W=8); expected odd
// values that depend on the saturation build follow HB_INTERP2_SAT_EN.
module tb_hb_interp2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic signed [7:0] o_data;
  logic              o_valid;
  logic              o_phase;
  logic              i_ready;

  int nvec = 0;
  int nbad = 0;

  hb_interp2 #(.DATA_W(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_phase   (o_phase),
    .i_ready   (i_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             nm;
    logic signed [7:0] x;
    logic signed [7:0] ee;
    logic signed [7:0] eo;
  } vec_t;

  vec_t tbl[14];
  int   fr_exp[10];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge: holds reset for two edges, returns at a negedge.
  task automatic do_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive inputs at the negedge, check outputs, move to next negedge.
  task automatic step(input string nm, input logic v, input logic signed [7:0] x,
                      input logic r, input logic ev, input int ed, input logic ep,
                      input logic er);
    i_valid = v; i_data = x; i_ready = r;
    #1;
    chk({nm, ".ready"}, o_ready, er);
    chk({nm, ".valid"}, o_valid, ev);
    if (ev) begin
      chk({nm, ".data"},  o_data,  ed);
      chk({nm, ".phase"}, o_phase, ep);
    end
    @(negedge clk);
  endtask

  // Push one sample and check its even/odd pair with the sink always ready.
  task automatic apply_vec(input vec_t t);
    int n;
    i_data = t.x; i_valid = 1'b1; i_ready = 1'b1;
    #1;
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({t.nm, ".accept"}, o_ready, 1);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk({t.nm, ".ev_valid"}, o_valid, 1);
    chk({t.nm, ".ev_phase"}, o_phase, 0);
    chk({t.nm, ".even"},     o_data,  t.ee);
    @(negedge clk);
    #1;
    chk({t.nm, ".od_valid"}, o_valid, 1);
    chk({t.nm, ".od_phase"}, o_phase, 1);
    chk({t.nm, ".odd"},      o_data,  t.eo);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{"step0",  8'sd16,   8'sd0,   -8'sd1};
    tbl[1]  = '{"step1",  8'sd16,   8'sd0,    8'sd8};
    tbl[2]  = '{"step2",  8'sd16,   8'sd16,   8'sd17};
    tbl[3]  = '{"step3",  8'sd16,   8'sd16,   8'sd16};
    tbl[4]  = '{"step4",  8'sd16,   8'sd16,   8'sd16};
    tbl[5]  = '{"ovs0",  -8'sd128,  8'sd0,    8'sd8};
    tbl[6]  = '{"ovs1",   8'sd127,  8'sd0,   -8'sd80};
    tbl[7]  = '{"ovs2",   8'sd127, -8'sd128, -8'sd8};
`ifdef HB_INTERP2_SAT_EN
    tbl[8]  = '{"ovs3",  -8'sd128,  8'sd127,  8'sd127};
    tbl[11] = '{"max2",   8'sd127,  8'sd127,  8'sd127};
`else
    tbl[8]  = '{"ovs3",  -8'sd128,  8'sd127, -8'sd97};
    tbl[11] = '{"max2",   8'sd127,  8'sd127, -8'sd121};
`endif
    tbl[9]  = '{"max0",   8'sd127,  8'sd0,   -8'sd8};
    tbl[10] = '{"max1",   8'sd127,  8'sd0,    8'sd64};
    tbl[12] = '{"max3",   8'sd127,  8'sd127,  8'sd127};
    tbl[13] = '{"max4",   8'sd127,  8'sd127,  8'sd127};
    fr_exp = '{0, -1, 0, 8, 16, 17, 16, 16, 16, 16};

    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    chk("rst.valid", o_valid, 0);
    chk("rst.data",  o_data,  0);
    chk("rst.phase", o_phase, 0);
    chk("rst.ready", o_ready, 1);
    @(negedge clk);

    // Table: step, overshoot, constant max, each from a clean delay line
    for (int i = 0; i < 14; i++) begin
      if (i == 5 || i == 9) do_reset();
      apply_vec(tbl[i]);
    end

    // Full rate: one input every other cycle, an output every cycle
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k >= 1)
        step($sformatf("full%0d", k), k <= 8, 8'sd16, 1'b1, 1'b1,
             fr_exp[k-1], 1'((k - 1) % 2), (k % 2) == 0);
      else
        step("full0", 1'b1, 8'sd16, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    end
    step("full_idle", 1'b0, 8'sd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Backpressure in S_EVEN then S_ODD; input held waiting the whole time
    do_reset();
    step("bp_acc", 1'b1, 8'sd16, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++)
      step($sformatf("bp_even%0d", k), 1'b1, 8'sd16, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    step("bp_even_go", 1'b1, 8'sd16, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      step($sformatf("bp_odd%0d", k), 1'b1, 8'sd16, 1'b0, 1'b1, -1, 1'b1, 1'b0);
    step("bp_odd_go", 1'b1, 8'sd16, 1'b1, 1'b1, -1, 1'b1, 1'b1);
    step("bp_ev2",    1'b0, 8'sd0,  1'b1, 1'b1, 0,  1'b0, 1'b0);
    step("bp_od2",    1'b0, 8'sd0,  1'b1, 1'b1, 8,  1'b1, 1'b1);
    step("bp_idle",   1'b0, 8'sd0,  1'b1, 1'b0, 0,  1'b0, 1'b1);

    // Reset mid-stream while presenting an even sample
    do_reset();
    step("mr_acc", 1'b1, 8'sd16, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step("mr_even", 1'b0, 8'sd0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mr_after.data", o_data, 0);
    step("mr_after", 1'b0, 8'sd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      vec_t t;
      t = tbl[i];
      t.nm = {"mr_", t.nm};
      apply_vec(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
